// File: rtl/alu_rf_pkg.sv
// Shared definitions for the ALU operand register file and the AND/OR ALU stage:
// geometry constants, bulk-clear FSM states, zero-register address and ALU ctrl codes.
package alu_rf_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam logic CTRL_AND = 1'b0;
  localparam logic CTRL_OR  = 1'b1;

  // Reference behaviour of the downstream ALU slice fed by the two read ports.
  function automatic logic [XLEN-1:0] alu_eval(input logic ctrl,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] y;
    y = '0;
    case (ctrl)
      CTRL_AND: y = a & b;
      CTRL_OR:  y = a | b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/alu_operand_regfile_rf_clear_fsm.sv
// Sequential bulk-clear engine: sweeps register indices 1..NREG-1, one per clock,
// after a clr_req pulse seen in IDLE. Requests during a sweep are ignored.
module rf_clear_fsm #(
  parameter int NREG = alu_rf_pkg::NREG,
  parameter int AW   = alu_rf_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);
  import alu_rf_pkg::*;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    clr_idx = cnt_q;
    case (state_q)
      RF_IDLE: begin
        // Register 0 is hardwired zero, so the sweep starts at index 1.
        if (clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = AW'(1);
        end
      end
      RF_CLEAR: begin
        clr_en = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RF_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge value of the others; the always_comb above uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RF_CLEAR);

endmodule

// File: rtl/alu_operand_regfile.sv
// Two-read/one-write register file feeding the AND/OR ALU A/B operands, with a
// sequential bulk-clear engine. Optional macro REGFILE_BYPASS_EN enables write-through reads.
module alu_operand_regfile #(
  parameter int XLEN = alu_rf_pkg::XLEN,
  parameter int NREG = alu_rf_pkg::NREG,
  parameter int AW   = alu_rf_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            clr_req,
  output logic            busy,
  output logic            wr_drop
);
  import alu_rf_pkg::*;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            clr_en;
  logic [AW-1:0]   clr_idx;
  logic            waddr_nz;
  logic            wr_en;

  rf_clear_fsm #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clear_fsm (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  assign waddr_nz = (waddr != ZERO_REG);
  assign wr_en    = we & ~busy & waddr_nz;
  assign wr_drop  = we &  busy & waddr_nz;

  // The sweep and a CPU write never coincide: writes are only accepted in IDLE.
  always_comb begin
    regs_d = regs_q;
    if (clr_en) begin
      regs_d[clr_idx] = '0;
    end else if (wr_en) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  // NOTE: the array carries a real reset because reset must architecturally
  // zero every register; this is why it is built from flops, not an SRAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != ZERO_REG) rdata1 = regs_q[raddr1];
    if (raddr2 != ZERO_REG) rdata2 = regs_q[raddr2];
`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes CLEAR and address 0, so forwarding does too.
    if (wr_en && (waddr == raddr1)) rdata1 = wdata;
    if (wr_en && (waddr == raddr2)) rdata2 = wdata;
`endif
  end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Self-checking bench for alu_operand_regfile: table-driven read/write vectors
// plus hand-written bulk-clear, dropped-write and asynchronous-reset sequences.
module tb_alu_operand_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        clr_req;
  logic        busy;
  logic        wr_drop;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  alu_operand_regfile dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .clr_req (clr_req),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs[9];

  logic [31:0] y;
  int          cyc;

  initial begin
    // Expected read values are the pre-edge view of each cycle.
    vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 5'd1,  32'hFFFF0000, 5'd1,  5'd2, BYP ? 32'hFFFF0000 : 32'h0, 32'h0};
    vecs[3] = '{1'b1, 5'd2,  32'h0F0F0F0F, 5'd1,  5'd2, 32'hFFFF0000, BYP ? 32'h0F0F0F0F : 32'h0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd2, 32'hFFFF0000, 32'h0F0F0F0F};
    vecs[5] = '{1'b1, 5'd3,  32'h5A5A5A5A, 5'd3,  5'd1, BYP ? 32'h5A5A5A5A : 32'h0, 32'hFFFF0000};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3, 32'h5A5A5A5A, 32'h5A5A5A5A};
    vecs[7] = '{1'b1, 5'd31, 32'h13579BDF, 5'd31, 5'd0, BYP ? 32'h13579BDF : 32'h0, 32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd2, 32'h13579BDF, 32'h0F0F0F0F};

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; clr_req = 1'b0;

    // Reset state: every address on both ports reads zero.
    #2;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_wr_drop", 32'(wr_drop), 32'h0);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1[%0d]", i), rdata1, 32'h0);
      check($sformatf("reset_rd2[%0d]", 31 - i), rdata2, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
      raddr1 = vecs[v].ra1; raddr2 = vecs[v].ra2;
      #1;
      check($sformatf("vec%0d_rdata1", v), rdata1, vecs[v].e1);
      check($sformatf("vec%0d_rdata2", v), rdata2, vecs[v].e2);
      check($sformatf("vec%0d_wr_drop", v), 32'(wr_drop), 32'h0);
    end
    @(negedge clk);
    we = 1'b0;

    // ALU operands from r1/r2 under both ctrl encodings.
    raddr1 = 5'd1; raddr2 = 5'd2;
    #1;
    y = rdata1 & rdata2;
    check("alu_and_y", y, 32'h0F0F0000);
    y = rdata1 | rdata2;
    check("alu_or_y", y, 32'hFFFF0F0F);

    // Fill r1..r31, then bulk clear.
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA5A5A5A5);
    raddr1 = 5'd1; raddr2 = 5'd31;
    #1;
    check("fill_r1", rdata1, 32'hA5A5A5A5);
    check("fill_r31", rdata2, 32'hA5A5A5A5);

    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      we = 1'b0; clr_req = 1'b0; waddr = '0; wdata = '0;
      if (cyc == 3) begin we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; end
      if (cyc == 4) begin we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; end
      if (cyc == 12) clr_req = 1'b1;
      #1;
      if (cyc == 3) check("clear_wr_drop_r5", 32'(wr_drop), 32'h1);
      if (cyc == 4) check("clear_wr_drop_r0", 32'(wr_drop), 32'h0);
      if (cyc == 10) begin
        check("mid_clear_r1", rdata1, 32'h0);
        check("mid_clear_r31", rdata2, 32'hA5A5A5A5);
      end
      @(negedge clk);
    end
    we = 1'b0; clr_req = 1'b0;
    check("busy_cycles", 32'(cyc), 32'd31);
    #1;
    check("post_clear_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      #1;
      check($sformatf("post_clear_r%0d", i), rdata1, 32'h0);
    end

    // Write + clr_req together in IDLE, then async reset mid-clear.
    write_reg(5'd20, 32'h11112222);
    @(negedge clk);
    we = 1'b1; waddr = 5'd30; wdata = 32'hCAFEF00D; clr_req = 1'b1;
    @(negedge clk);
    we = 1'b0; clr_req = 1'b0;
    raddr1 = 5'd20; raddr2 = 5'd30;
    cyc = 1;
    while (busy && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    check("pre_rst_busy", 32'(busy), 32'h1);
    check("pre_rst_r20", rdata1, 32'h11112222);
    check("pre_rst_r30", rdata2, 32'hCAFEF00D);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_r20", rdata1, 32'h0);
    check("async_rst_r30", rdata2, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_rst_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
